nibble_serial_adder_16bit: RTL and testbench

NIBBLE_SERIAL_ADDER_16BIT -- requirements
Module: nibble_serial_adder_16bit

---
 rtl/nibble_serial_adder_16bit.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder_16bit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_16bit.sv
// 16-bit adder that reuses one 4-bit ripple-carry adder, processing one nibble per clock.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to drive the signed-overflow output; otherwise it is tied to 0.

module nibble_serial_adder_16bit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] left,
   input  logic [15:0] right,
   input  logic        carry_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum,
   output logic        carry_out,
   output logic        overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_left;
   logic [15:0] r_right;
   logic        r_carry;
   logic [1:0]  r_idx;
   logic [15:0] r_sum;
   logic        r_carry_out;
   logic [3:0]  w_nib_l;
   logic [3:0]  w_nib_r;
   logic [3:0]  w_nib_s;
   logic        w_nib_c;

   assign w_nib_l = r_left[{r_idx, 2'b00} +: 4];
   assign w_nib_r = r_right[{r_idx, 2'b00} +: 4];

   ripple_carry_adder_4bit u_rca (
      .left      (w_nib_l),
      .right     (w_nib_r),
      .carry_in  (r_carry),
      .sum       (w_nib_s),
      .carry_out (w_nib_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_state_next = S_RUN;
            else          w_state_next = S_IDLE;
         end
         S_RUN: begin
            if (r_idx == 2'd3) w_state_next = S_DONE;
            else               w_state_next = S_RUN;
         end
         S_DONE: begin
            if (out_ready) w_state_next = S_IDLE;
            else           w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Operands are captured once at acceptance so port changes during RUN cannot disturb the add.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_left      <= 16'd0;
         r_right     <= 16'd0;
         r_carry     <= 1'b0;
         r_idx       <= 2'd0;
         r_sum       <= 16'd0;
         r_carry_out <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_left  <= left;
                  r_right <= right;
                  r_carry <= carry_in;
                  r_idx   <= 2'd0;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_nib_s;
               r_carry                    <= w_nib_c;
               r_idx                      <= r_idx + 2'd1;
               if (r_idx == 2'd3) r_carry_out <= w_nib_c;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
   logic r_overflow;
   logic w_carry_into_msb;

   // Carry into bit 15 is recovered from the top nibble's sum bit, avoiding an extra adder port.
   assign w_carry_into_msb = w_nib_s[3] ^ w_nib_l[3] ^ w_nib_r[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if ((r_state == S_RUN) && (r_idx == 2'd3)) begin
         r_overflow <= w_carry_into_msb ^ w_nib_c;
      end
   end

   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   assign sum       = r_sum;
   assign carry_out = r_carry_out;
   assign in_ready  = (r_state == S_IDLE) && !reset;
   assign out_valid = (r_state == S_DONE);

endmodule

module ripple_carry_adder_4bit (
   input  logic [3:0] left,
   input  logic [3:0] right,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry_out
);

   logic [4:0] w_c;

   always_comb begin
      w_c[0] = carry_in;
      for (int k = 0; k < 4; k++) begin
         sum[k]   = left[k] ^ right[k] ^ w_c[k];
         w_c[k+1] = (left[k] & right[k]) | (w_c[k] & (left[k] ^ right[k]));
      end
      carry_out = w_c[4];
   end

endmodule

// File: tb/tb_nibble_serial_adder_16bit.sv
// Self-checking bench for nibble_serial_adder_16bit: directed corner cases plus a randomized
// per-lane nibble sweep, compared against a plain-arithmetic reference model.

module tb_nibble_serial_adder_16bit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] left;
   logic [15:0] right;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        carry_out;
   logic        overflow;

   int n_cmp;
   int n_err;
   int cycle;

   nibble_serial_adder_16bit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .left      (left),
      .right     (right),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Reference: {overflow, carry_out, sum} from whole-word arithmetic.
   function automatic logic [17:0] model(input logic [15:0] l, input logic [15:0] r, input logic c);
      logic [16:0] t;
      logic        v;
      t = {1'b0, l} + {1'b0, r} + {16'd0, c};
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      v = (l[15] == r[15]) && (t[15] != l[15]);
`else
      v = 1'b0;
`endif
      return {v, t};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one operand set, then scrambles the ports and waits (bounded) for out_valid.
   task automatic do_op(input logic [15:0] l, input logic [15:0] r, input logic c, output int lat);
      int n;
      left = l; right = r; carry_in = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      left = 16'($urandom); right = 16'($urandom); carry_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      left = 16'd0; right = 16'd0; carry_in = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if ({out_valid, in_ready, sum, carry_out, overflow} !== 20'd0) begin
         n_err++;
         $display("FAIL reset_state: got ov=%b ir=%b sum=%h co=%b of=%b want all 0",
                  out_valid, in_ready, sum, carry_out, overflow);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [15:0] vl [0:5];
      logic [15:0] vr [0:5];
      logic        vc [0:5];
      logic [17:0] exp;
      int lat;
      vl = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000};
      vr = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         exp = model(vl[k], vr[k], vc[k]);
         do_op(vl[k], vr[k], vc[k], lat);
         n_cmp++;
         if (lat !== 4) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d want 4", k, lat);
         end
         n_cmp++;
         if ({overflow, carry_out, sum} !== exp) begin
            n_err++;
            $display("FAIL directed_result[%0d]: %h+%h+%b got of=%b co=%b sum=%h want of=%b co=%b sum=%h",
                     k, vl[k], vr[k], vc[k], overflow, carry_out, sum, exp[17], exp[16], exp[15:0]);
         end
         release_result();
         n_cmp++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL directed_release[%0d]: got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] exp;
      int lat;
      exp = model(16'h1234, 16'h4321, 1'b1);
      do_op(16'h1234, 16'h4321, 1'b1, lat);
      n_cmp++;
      if (lat !== 4 || {overflow, carry_out, sum} !== exp || exp[16:0] !== 17'h05556) begin
         n_err++;
         $display("FAIL hold_result: got lat=%0d co=%b sum=%h want lat=4 co=0 sum=5556", lat, carry_out, sum);
      end
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            in_valid = 1'b1; left = 16'hAAAA; right = 16'h5555; carry_in = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         n_cmp++;
         if ({out_valid, in_ready, overflow, carry_out, sum} !== {2'b10, exp}) begin
            n_err++;
            $display("FAIL hold_stable[%0d]: got ov=%b ir=%b co=%b sum=%h want ov=1 ir=0 co=%b sum=%h",
                     k, out_valid, in_ready, carry_out, sum, exp[16], exp[15:0]);
         end
      end
      in_valid = 1'b0;
      release_result();
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_pulse_ignored[%0d]: got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [17:0] exp;
      int lat;
      left = 16'hFFFF; right = 16'hFFFF; carry_in = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid, in_ready, sum, carry_out, overflow} !== 20'd0) begin
         n_err++;
         $display("FAIL midrun_reset: got ov=%b ir=%b sum=%h co=%b of=%b want all 0",
                  out_valid, in_ready, sum, carry_out, overflow);
      end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL midrun_discard[%0d]: got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready);
         end
      end
      exp = model(16'h8000, 16'h8000, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, lat);
      n_cmp++;
      if (lat !== 4 || {overflow, carry_out, sum} !== exp || exp[16:0] !== 17'h10000) begin
         n_err++;
         $display("FAIL after_reset_op: got lat=%0d of=%b co=%b sum=%h want lat=4 of=%b co=1 sum=0000",
                  lat, overflow, carry_out, sum, exp[17]);
      end
      release_result();
   endtask

   // Every nibble pair in every lane with both carry-ins; handshakes held high throughout.
   task automatic test_back_to_back();
      logic [15:0] l;
      logic [15:0] r;
      logic        c;
      logic [7:0]  pair;
      logic [17:0] exp;
      int n;
      int acc;
      int prev_acc;
      bit abort;
      prev_acc = -1;
      abort    = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int lane = 0; lane < 4 && !abort; lane++) begin
         for (int ci = 0; ci < 2 && !abort; ci++) begin
            for (int p = 0; p < 256 && !abort; p++) begin
               pair = p[7:0];
               c = ci[0];
               l = 16'($urandom); r = 16'($urandom);
               l[4*lane +: 4] = pair[3:0];
               r[4*lane +: 4] = pair[7:4];
               left = l; right = r; carry_in = c;
               exp = model(l, r, c);
               n = 0;
               while (!in_ready && n < 10) begin
                  tick();
                  n++;
               end
               tick();
               acc = cycle;
               left = 16'($urandom); right = 16'($urandom); carry_in = 1'($urandom);
               if (prev_acc >= 0) begin
                  n_cmp++;
                  if (acc - prev_acc !== 6) begin
                     n_err++;
                     $display("FAIL b2b_spacing: got %0d want 6", acc - prev_acc);
                  end
               end
               prev_acc = acc;
               n = 0;
               while (!out_valid && n < 10) begin
                  tick();
                  n++;
               end
               n_cmp++;
               if (cycle - acc !== 4) begin
                  n_err++;
                  $display("FAIL b2b_latency: got %0d want 4", cycle - acc);
                  abort = 1'b1;
               end
               n_cmp++;
               if ({overflow, carry_out, sum} !== exp) begin
                  n_err++;
                  $display("FAIL b2b_result: %h+%h+%b got of=%b co=%b sum=%h want of=%b co=%b sum=%h",
                           l, r, c, overflow, carry_out, sum, exp[17], exp[16], exp[15:0]);
               end
            end
         end
      end
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
